// File: rtl/core_sequencer_if.sv
// Handshake/status bundle between the RiscyD2 core datapath and its
// control sequencer. The sequencer attaches through the slave modport.
interface core_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_ready_i;
  logic            mem_req_i;
  logic            lsu_ready_i;
  logic            ex_stall_i;
  logic            trap_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] branch_target_i;
  logic            halt_req_i;
  logic            step_i;

  logic [2:0]      state_o;
  logic [XLEN-1:0] pc_o;
  logic            retire_o;
  logic            halted_o;
  logic [XLEN-1:0] epc_o;
  logic [1:0]      cause_o;
  logic [63:0]     instret_o;

  modport master (
    output fetch_ready_i, mem_req_i, lsu_ready_i, ex_stall_i, trap_i,
           branch_taken_i, branch_target_i, halt_req_i, step_i,
    input  state_o, pc_o, retire_o, halted_o, epc_o, cause_o, instret_o
  );

  modport slave (
    input  fetch_ready_i, mem_req_i, lsu_ready_i, ex_stall_i, trap_i,
           branch_taken_i, branch_target_i, halt_req_i, step_i,
    output state_o, pc_o, retire_o, halted_o, epc_o, cause_o, instret_o
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RiscyD2 core: drives the phase
// consumed by rf/csr_rf/execute/mmio, owns the PC, handles memory wait
// states, execute stalls, trap redirect, debug halt/step and instret.
module core_sequencer #(
  parameter int unsigned   XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input logic            clk_i,
  input logic            rst_ni,
  core_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    EXECUTE_2  = 3'd3,
    WRITE_BACK = 3'd4,
    TRAP       = 3'd5,
    HALT       = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TRAP     = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  cause_t          cause_q, cause_d;
  cause_t          pend_q, pend_d;
  logic [63:0]     instret_q, instret_d;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;
  logic            mem_wait;

  assign mem_wait = bus.mem_req_i && !bus.lsu_ready_i;

  // Next-state and architectural-state update for the instruction lifecycle
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    pend_d    = pend_q;
    instret_d = instret_q;
    retire_d  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (bus.fetch_ready_i) state_d = DECODE;
      end
      DECODE: begin
        if (bus.trap_i) begin
          state_d = TRAP;
          pend_d  = CAUSE_TRAP;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (bus.trap_i) begin
          state_d = TRAP;
          pend_d  = CAUSE_TRAP;
        end else begin
          state_d = EXECUTE_2;
        end
      end
      EXECUTE_2: begin
        if (bus.trap_i) begin
          state_d = TRAP;
          pend_d  = CAUSE_TRAP;
        end else if (!(bus.ex_stall_i || mem_wait)) begin
          state_d = WRITE_BACK;
        end
      end
      WRITE_BACK: begin
        if (bus.branch_taken_i && (bus.branch_target_i[1:0] != 2'b00)) begin
          // Misaligned redirect: instruction does not retire, PC kept as EPC
          state_d = TRAP;
          pend_d  = CAUSE_MISALIGN;
        end else begin
          pc_d      = bus.branch_taken_i ? bus.branch_target_i : pc_q + XLEN'(4);
          retire_d  = 1'b1;
          instret_d = instret_q + 64'd1;
          state_d   = bus.halt_req_i ? HALT : FETCH;
        end
      end
      TRAP: begin
        epc_d   = pc_q;
        cause_d = pend_q;
        pc_d    = TRAP_VECTOR;
        state_d = FETCH;
      end
      HALT: begin
        if (!bus.halt_req_i || bus.step_i) state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  // State and architectural registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      cause_q   <= CAUSE_NONE;
      pend_q    <= CAUSE_NONE;
      instret_q <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      pend_q    <= pend_d;
      instret_q <= instret_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.pc_o      = pc_q;
  assign bus.retire_o  = retire_q;
  assign bus.halted_o  = halted_q;
  assign bus.epc_o     = epc_q;
  assign bus.cause_o   = cause_q;
  assign bus.instret_o = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios followed by
// randomized stimulus, all outputs compared each cycle to a reference model.
module tb_core_sequencer;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_pass;

  core_sequencer_if #(.XLEN(32)) bus ();

  core_sequencer #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (TRAP_VEC)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view of the sequencer
  int          m_phase;
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause, m_pend;
  logic [63:0] m_instret;
  bit          m_retire, m_halted;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = '0; m_epc = '0; m_cause = '0; m_pend = '0;
    m_instret = '0; m_retire = 0; m_halted = 0;
  endtask

  task automatic model_step();
    int nxt;
    logic [31:0] tgt;
    logic br;
    nxt = m_phase;
    m_retire = 0;
    tgt = bus.branch_target_i;
    br = bus.branch_taken_i;
    if (m_phase >= 1 && m_phase <= 3 && bus.trap_i) begin
      nxt = 5;
      m_pend = 2'd1;
    end else begin
      case (m_phase)
        0: if (bus.fetch_ready_i) nxt = 1;
        1, 2: nxt = m_phase + 1;
        3: if (!bus.ex_stall_i && !(bus.mem_req_i && !bus.lsu_ready_i)) nxt = 4;
        4: begin
          if (br && tgt[1:0] != 2'b00) begin
            nxt = 5;
            m_pend = 2'd2;
          end else begin
            m_pc = br ? tgt : m_pc + 32'd4;
            m_retire = 1;
            m_instret = m_instret + 64'd1;
            nxt = bus.halt_req_i ? 6 : 0;
          end
        end
        5: begin
          m_epc = m_pc;
          m_cause = m_pend;
          m_pc = TRAP_VEC;
          nxt = 0;
        end
        6: if (!bus.halt_req_i || bus.step_i) nxt = 0;
        default: nxt = 0;
      endcase
    end
    m_phase = nxt;
    m_halted = (nxt == 6);
  endtask

  task automatic compare_all();
    check_eq("state", 64'(bus.state_o), 64'(m_phase));
    check_eq("pc", 64'(bus.pc_o), 64'(m_pc));
    check_eq("retire", 64'(bus.retire_o), 64'(m_retire));
    check_eq("halted", 64'(bus.halted_o), 64'(m_halted));
    check_eq("epc", 64'(bus.epc_o), 64'(m_epc));
    check_eq("cause", 64'(bus.cause_o), 64'(m_cause));
    check_eq("instret", bus.instret_o, m_instret);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    bus.fetch_ready_i = 1; bus.mem_req_i = 0; bus.lsu_ready_i = 1;
    bus.ex_stall_i = 0; bus.trap_i = 0; bus.branch_taken_i = 0;
    bus.branch_target_i = '0; bus.halt_req_i = 0; bus.step_i = 0;
  endtask

  task automatic run_instr(input int n);
    for (int i = 0; i < n * 5; i++) run_cycle();
  endtask

  task automatic branch_instr(input logic [31:0] tgt);
    bus.branch_taken_i = 1;
    bus.branch_target_i = tgt;
    run_instr(1);
    bus.branch_taken_i = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, 64'(bus.state_o), 64'd0);
    check_eq({tag, "_pc"}, 64'(bus.pc_o), 64'd0);
    check_eq({tag, "_retire"}, 64'(bus.retire_o), 64'd0);
    check_eq({tag, "_halted"}, 64'(bus.halted_o), 64'd0);
    check_eq({tag, "_epc"}, 64'(bus.epc_o), 64'd0);
    check_eq({tag, "_cause"}, 64'(bus.cause_o), 64'd0);
    check_eq({tag, "_instret"}, bus.instret_o, 64'd0);
  endtask

  initial begin
    int rcount;
    logic [63:0] ir_before;
    n_checks = 0;
    n_pass = 0;
    set_idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;

    // Straight-line: five-cycle phase sequence, retire every fifth cycle
    for (int k = 1; k <= 15; k++) begin
      run_cycle();
      check_eq("seq_state", 64'(bus.state_o), 64'(k % 5));
      check_eq("seq_retire", 64'(bus.retire_o), 64'((k % 5) == 0));
    end
    check_eq("seq_instret", bus.instret_o, 64'd3);
    check_eq("seq_pc", 64'(bus.pc_o), 64'd12);

    // Wait states on fetch and load/store: ten-cycle instruction
    rcount = 0;
    bus.mem_req_i = 1;
    for (int i = 1; i <= 10; i++) begin
      bus.fetch_ready_i = (i >= 4);
      bus.lsu_ready_i = (i >= 9);
      run_cycle();
      if (i == 9) check_eq("ws_state9", 64'(bus.state_o), 64'd4);
      rcount += int'(bus.retire_o);
    end
    set_idle();
    check_eq("ws_retires", 64'(rcount), 64'd1);
    check_eq("ws_retire_last", 64'(bus.retire_o), 64'd1);
    check_eq("ws_instret", bus.instret_o, 64'd4);

    // Branches, then a misaligned target
    run_instr(4);
    check_eq("br_pc_start", 64'(bus.pc_o), 64'h20);
    branch_instr(32'h80);
    check_eq("br_pc_80", 64'(bus.pc_o), 64'h80);
    branch_instr(32'h20);
    check_eq("br_pc_20", 64'(bus.pc_o), 64'h20);
    ir_before = bus.instret_o;
    bus.branch_taken_i = 1;
    bus.branch_target_i = 32'h82;
    run_instr(1);
    set_idle();
    check_eq("mis_state", 64'(bus.state_o), 64'd5);
    check_eq("mis_retire", 64'(bus.retire_o), 64'd0);
    run_cycle();
    check_eq("mis_epc", 64'(bus.epc_o), 64'h20);
    check_eq("mis_cause", 64'(bus.cause_o), 64'd2);
    check_eq("mis_pc", 64'(bus.pc_o), 64'h100);
    check_eq("mis_instret", bus.instret_o, ir_before);

    // Trap wins over an execute stall in EXECUTE_2
    branch_instr(32'h44);
    check_eq("tp_pc", 64'(bus.pc_o), 64'h44);
    repeat (3) run_cycle();
    bus.trap_i = 1;
    bus.ex_stall_i = 1;
    run_cycle();
    set_idle();
    check_eq("tp_state", 64'(bus.state_o), 64'd5);
    run_cycle();
    check_eq("tp_epc", 64'(bus.epc_o), 64'h44);
    check_eq("tp_cause", 64'(bus.cause_o), 64'd1);
    check_eq("tp_pc_vec", 64'(bus.pc_o), 64'h100);

    // Halt requested mid-instruction, then single-step, then resume
    repeat (2) run_cycle();
    bus.halt_req_i = 1;
    repeat (3) run_cycle();
    check_eq("hl_state", 64'(bus.state_o), 64'd6);
    check_eq("hl_halted", 64'(bus.halted_o), 64'd1);
    check_eq("hl_retire", 64'(bus.retire_o), 64'd1);
    check_eq("hl_pc", 64'(bus.pc_o), 64'h104);
    repeat (4) run_cycle();
    check_eq("hl_pc_stable", 64'(bus.pc_o), 64'h104);
    bus.step_i = 1;
    run_cycle();
    bus.step_i = 0;
    rcount = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      rcount += int'(bus.retire_o);
    end
    check_eq("st_retires", 64'(rcount), 64'd1);
    check_eq("st_state", 64'(bus.state_o), 64'd6);
    check_eq("st_pc", 64'(bus.pc_o), 64'h108);
    bus.halt_req_i = 0;
    run_cycle();
    check_eq("rs_state", 64'(bus.state_o), 64'd0);
    check_eq("rs_halted", 64'(bus.halted_o), 64'd0);

    // Asynchronous reset during EXECUTE_2
    repeat (3) run_cycle();
    check_eq("ar_pre_state", 64'(bus.state_o), 64'd3);
    #2;
    rst_n = 0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // PC wraps from the top of the address space
    branch_instr(32'hFFFF_FFFC);
    check_eq("wr_pc_top", 64'(bus.pc_o), 64'hFFFF_FFFC);
    run_instr(1);
    check_eq("wr_pc_zero", 64'(bus.pc_o), 64'd0);

    // Randomized stimulus
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
      bus.mem_req_i = $urandom_range(0, 1);
      bus.lsu_ready_i = ($urandom_range(0, 2) != 0);
      bus.ex_stall_i = ($urandom_range(0, 4) == 0);
      bus.trap_i = ($urandom_range(0, 19) == 0);
      bus.branch_taken_i = ($urandom_range(0, 2) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      bus.branch_target_i = tgt;
      if ($urandom_range(0, 29) == 0) bus.halt_req_i = ~bus.halt_req_i;
      bus.step_i = ($urandom_range(0, 9) == 0);
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
